dpb_apb_ctrl: RTL

APB slave that acts as the initiator on port A of the 128×16 dual-port block RAM. It converts CPU APB reads and writes into RAM port accesses and absorbs the RAM read latency with APB wait states. It also contains a hardware fill engine that writes one 16-bit value to all 128 words. Port B stays free for the fabric-side consumer.

---
 rtl/dpb_apb_ctrl_pkg.sv | 25 ++
 rtl/dpb_apb_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/dpb_apb_ctrl_pkg.sv
// Shared types and constants for the APB front end of the 128x16 dual-port
// block RAM (port A side).
package dpb_apb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RD_CAP,
    S_RESP,
    S_FILL
  } state_e;

  localparam logic [9:0] ADDR_CTRL     = 10'h200;
  localparam logic [9:0] ADDR_STATUS   = 10'h204;
  localparam logic [9:0] ADDR_ERR_BASE = 10'h208;

  localparam int RAM_DEPTH = 128;
  localparam int RAM_AW    = 7;

  // APB byte address to word index; the two lowest address bits are ignored.
  function automatic logic [7:0] word_of(input logic [9:0] addr);
    return addr[9:2];
  endfunction

endpackage

// File: rtl/dpb_apb_ctrl.sv
// APB slave driving port A of the 128x16 dual-port block RAM.
// CPU reads/writes of the RAM window become RAM port accesses (reads stretched
// with wait states to cover the RAM read latency); a fill engine can write one
// 16-bit value to all 128 words.
//
// Ports
//   clk_i, reset_i        system clock, async active-high reset
//   psel_i, penable_i,
//   pwrite_i, paddr_i,
//   pwdata_i              APB request
//   prdata_o, pready_o,
//   pslverr_o             APB response (all registered)
//   ram_ad_o, ram_din_o,
//   ram_wre_o, ram_ce_o   RAM port A command
//   ram_oce_o, ram_reset_o  tied 1 / 0
//   ram_dout_i            RAM port A read data
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no RAM activity; decodes each APB setup phase
// S_RD_WAIT | read issued; counting down the remaining RAM latency
// S_RD_CAP  | ram_dout valid; capture into prdata
// S_RESP    | pready high for the read
// S_FILL    | fill engine writing ram_ad = 0..127, one word per cycle
module dpb_apb_ctrl
  import dpb_apb_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                psel_i,
  input  logic                penable_i,
  input  logic                pwrite_i,
  input  logic [9:0]          paddr_i,
  input  logic [31:0]         pwdata_i,
  output logic [31:0]         prdata_o,
  output logic                pready_o,
  output logic                pslverr_o,
  output logic [RAM_AW-1:0]   ram_ad_o,
  output logic [15:0]         ram_din_o,
  output logic                ram_wre_o,
  output logic                ram_ce_o,
  output logic                ram_oce_o,
  output logic                ram_reset_o,
  input  logic [15:0]         ram_dout_i
);

  localparam logic [1:0] WAIT_INIT = 2'(RD_LATENCY - 1);

  state_e              state_q;
  logic [31:0]         prdata_q;
  logic                pready_q;
  logic                pslverr_q;
  logic                ram_ce_q;
  logic                ram_wre_q;
  logic [RAM_AW-1:0]   ram_ad_q;
  logic [15:0]         ram_din_q;
  logic                busy_q;
  logic                done_q;
  logic [1:0]          wait_q;

  logic [7:0]          word;
  logic                sel_ram;
  logic                sel_ctrl;
  logic                sel_status;
  logic                sel_err;
  logic                fill_last;
  logic                ram_go;
  logic                reg_go;
  logic                unused_addr;

  assign word        = word_of(paddr_i);
  assign sel_ram     = ~paddr_i[9];
  assign sel_ctrl    = (word == ADDR_CTRL[9:2]);
  assign sel_status  = (word == ADDR_STATUS[9:2]);
  assign sel_err     = paddr_i[9] & (word >= ADDR_ERR_BASE[9:2]);
  assign unused_addr = ^paddr_i[1:0];

  assign fill_last = (state_q == S_FILL) && (ram_ad_q == RAM_AW'(RAM_DEPTH - 1));

  // Outputs are registered, so requests are decoded in the setup phase and
  // become visible in the first access cycle. A RAM access held off by the
  // fill is launched on the last fill cycle, whatever phase APB is in.
  assign ram_go = psel_i & sel_ram &
                  (((state_q == S_IDLE) & ~penable_i) | fill_last);
  assign reg_go = psel_i & ~penable_i & ~sel_ram &
                  ((state_q == S_IDLE) | (state_q == S_FILL));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      ram_ce_q  <= 1'b0;
      ram_wre_q <= 1'b0;
      ram_ad_q  <= '0;
      ram_din_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wait_q    <= '0;
    end else begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          ram_ce_q  <= 1'b0;
          ram_wre_q <= 1'b0;
        end
        S_RD_WAIT: begin
          ram_ce_q <= 1'b0;
          if (wait_q == 2'd0) state_q <= S_RD_CAP;
          else                wait_q  <= wait_q - 2'd1;
        end
        S_RD_CAP: begin
          prdata_q <= {16'h0, ram_dout_i};
          pready_q <= 1'b1;
          state_q  <= S_RESP;
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        S_FILL: begin
          if (fill_last) begin
            ram_ce_q  <= 1'b0;
            ram_wre_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            ram_ad_q <= ram_ad_q + RAM_AW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (ram_go) begin
        ram_ce_q  <= 1'b1;
        ram_wre_q <= pwrite_i;
        ram_ad_q  <= paddr_i[8:2];
        if (pwrite_i) begin
          ram_din_q <= pwdata_i[15:0];
          pready_q  <= 1'b1;
        end else begin
          wait_q  <= WAIT_INIT;
          state_q <= S_RD_WAIT;
        end
      end

      if (reg_go) begin
        pready_q  <= 1'b1;
        pslverr_q <= sel_err;
        prdata_q  <= (sel_status && !pwrite_i) ? {30'h0, done_q, busy_q} : 32'h0;
        if (sel_status && pwrite_i && pwdata_i[1]) done_q <= 1'b0;
        // Start is placed after the done-clear so it wins if both apply.
        if (sel_ctrl && pwrite_i && pwdata_i[0] && !busy_q) begin
          busy_q    <= 1'b1;
          done_q    <= 1'b0;
          state_q   <= S_FILL;
          ram_ce_q  <= 1'b1;
          ram_wre_q <= 1'b1;
          ram_ad_q  <= '0;
          ram_din_q <= pwdata_i[31:16];
        end
      end
    end
  end

  assign prdata_o    = prdata_q;
  assign pready_o    = pready_q;
  assign pslverr_o   = pslverr_q;
  assign ram_ce_o    = ram_ce_q;
  assign ram_wre_o   = ram_wre_q;
  assign ram_ad_o    = ram_ad_q;
  assign ram_din_o   = ram_din_q;
  assign ram_oce_o   = 1'b1;
  assign ram_reset_o = 1'b0;

endmodule
